// File: rtl/i2s_pkg.sv
// Constants shared by the I2S framer, transmitter and receiver.
// The half-frame encoding follows lrck: 0 = left, 1 = right.
package i2s_pkg;

   localparam int unsigned WORD_BITS_DEF = 24;

   typedef enum logic {
      HalfLeft  = 1'b0,
      HalfRight = 1'b1
   } half_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for stereo sample pairs, clocked on the falling bck edge.
// The head word is visible combinationally; the caller gates push/pop on level.
module sample_fifo #(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;

   // DEPTH is a power of two, so the pointers wrap on natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(negedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/i2s_tx_framer.sv
// Frames buffered stereo pairs into I2S half-frames: runs the bit counter and lrck,
// loads the left word (popping the FIFO) at each left start and the right word at right start.
module i2s_tx_framer
   import i2s_pkg::*;
#(
   parameter int unsigned WORD_BITS  = WORD_BITS_DEF,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          bck,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic signed [WORD_BITS-1:0]   s_left,
   input  logic signed [WORD_BITS-1:0]   s_right,
   output logic                          lrck,
   output logic signed [WORD_BITS-1:0]   l_din,
   output logic signed [WORD_BITS-1:0]   r_din,
   output logic                          underrun,
   output logic [15:0]                   underrun_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned CW = $clog2(WORD_BITS);
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   logic [CW-1:0]        word_cnt_q, word_cnt_d;
   half_e                lrck_q, lrck_d;
   logic [WORD_BITS-1:0] l_din_q, l_din_d;
   logic [WORD_BITS-1:0] r_din_q, r_din_d;
   logic [WORD_BITS-1:0] r_pend_q, r_pend_d;
   logic                 underrun_q, underrun_d;
   logic [15:0]          underrun_cnt_q, underrun_cnt_d;

   logic                   push, pop;
   logic [2*WORD_BITS-1:0] head;
   logic [LW-1:0]          level;

   assign s_ready = (level < LW'(FIFO_DEPTH));
   assign push    = s_valid && s_ready;

   sample_fifo #(
      .WIDTH (2 * WORD_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (bck),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({s_left, s_right}),
      .rdata (head),
      .level (level)
   );

   always_comb begin
      word_cnt_d     = word_cnt_q;
      lrck_d         = lrck_q;
      l_din_d        = l_din_q;
      r_din_d        = r_din_q;
      r_pend_d       = r_pend_q;
      underrun_d     = 1'b0;
      underrun_cnt_d = underrun_cnt_q;
      pop            = 1'b0;
      if (!en) begin
         word_cnt_d = '0;
         lrck_d     = HalfLeft;
         l_din_d    = '0;
         r_din_d    = '0;
         r_pend_d   = '0;
      end else if (word_cnt_q == CW'(WORD_BITS - 1)) begin
         word_cnt_d = '0;
         if (lrck_q == HalfRight) begin
            lrck_d = HalfLeft;
            // Emptiness is judged on the stored level, so a same-edge push is not popped.
            if (level != '0) begin
               pop      = 1'b1;
               l_din_d  = head[2*WORD_BITS-1 -: WORD_BITS];
               r_pend_d = head[WORD_BITS-1:0];
            end else begin
               l_din_d    = '0;
               r_pend_d   = '0;
               underrun_d = 1'b1;
               if (underrun_cnt_q != 16'hFFFF) begin
                  underrun_cnt_d = underrun_cnt_q + 16'd1;
               end
            end
         end else begin
            lrck_d  = HalfRight;
            r_din_d = r_pend_q;
         end
      end else begin
         word_cnt_d = word_cnt_q + CW'(1);
      end
   end

   always_ff @(negedge bck) begin
      if (rst) begin
         word_cnt_q     <= '0;
         lrck_q         <= HalfLeft;
         l_din_q        <= '0;
         r_din_q        <= '0;
         r_pend_q       <= '0;
         underrun_q     <= 1'b0;
         underrun_cnt_q <= '0;
      end else begin
         word_cnt_q     <= word_cnt_d;
         lrck_q         <= lrck_d;
         l_din_q        <= l_din_d;
         r_din_q        <= r_din_d;
         r_pend_q       <= r_pend_d;
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign lrck         = lrck_q;
   assign l_din        = l_din_q;
   assign r_din        = r_din_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = underrun_cnt_q;
   assign fifo_level   = level;

endmodule

// File: doc/i2s_tx_framer.md
I2S_TX_FRAMER -- requirements
Module: i2s_tx_framer

Interface
REQ-001 SHALL have parameter WORD_BITS, default 24: sample width and bck cycles per half-frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: stereo pairs buffered; power of two, at least 2.
REQ-003 SHALL have port bck, input, 1: sole clock; all state updates on the falling edge of bck.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: frame generation enable.
REQ-006 SHALL have ports s_valid (input, 1) and s_ready (output, 1): sample-pair handshake.
REQ-007 SHALL have ports s_left and s_right, input, WORD_BITS, signed: offered stereo pair.
REQ-008 SHALL have port lrck, output, 1: 0 = left half-frame, 1 = right half-frame.
REQ-009 SHALL have ports l_din and r_din, output, WORD_BITS, signed: words presented to i2s_tx.
REQ-010 SHALL have port underrun, output, 1: one-cycle pulse on a mute load.
REQ-011 SHALL have port underrun_cnt, output, 16: saturating underrun count.
REQ-012 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1: pairs currently stored.

Function
REQ-013 SHALL run bit counter word_cnt 0..WORD_BITS-1 while en=1, incrementing once per bck.
REQ-014 SHALL, at word_cnt=WORD_BITS-1, wrap word_cnt to 0 and toggle lrck in the same edge; each half-frame is exactly WORD_BITS bck.
REQ-015 SHALL perform a left-load at every 1->0 lrck toggle: pop FIFO head, load l_din with its left word, latch its right word in r_pend.
REQ-016 SHALL perform a right-load at every 0->1 lrck toggle: load r_din from r_pend.
REQ-017 SHALL, on left-load with FIFO empty, load l_din=0 and r_pend=0, pulse underrun, and increment underrun_cnt, saturating at 16'hFFFF.
REQ-018 SHALL drive s_ready = (fifo_level < FIFO_DEPTH), combinationally from stored level only.
REQ-019 SHALL accept a pair when s_valid and s_ready are both 1 on a falling edge; offers while full are not stored and are not lost from the source's view.
REQ-020 SHALL, on simultaneous push and pop, leave fifo_level unchanged; a push into an empty FIFO at a left-load edge SHALL NOT be popped on that edge (underrun taken).
REQ-021 SHALL preserve pair order; left and right words of one pair SHALL always emit in the same frame.
REQ-022 SHALL, while en=0, hold word_cnt=0 and lrck=0, drive l_din=r_din=0, perform no loads, and still accept pushes.
REQ-023 SHALL, on en 0->1, begin with a left half-frame at word_cnt=0; the first popped pair emits after the first right half-frame.
REQ-024 SHALL drive underrun only from the left-load edge; a right-load never signals underrun.

Reset
REQ-025 SHALL, with rst=1 on a falling bck edge, clear word_cnt, lrck, l_din, r_din, r_pend, underrun, underrun_cnt, and fifo_level to 0, discarding buffered pairs.
REQ-026 SHALL give rst priority over en and over any simultaneous push or load; mid-frame reset restarts at a left half-frame.

Structure
REQ-027 SHALL take WORD_BITS default and the half-frame encoding constants from shared package i2s_pkg, also used by i2s_tx and i2s_rx.
REQ-028 SHALL implement buffering in one sub-module, sample_fifo: synchronous, 2*WORD_BITS wide, FIFO_DEPTH deep, with level output.
REQ-029 SHALL keep counter, lrck, and load logic in i2s_tx_framer with no other sub-modules.

Verification
REQ-030 SHALL cover the following directed scenarios:
- Reset, en=1, no pushes -> lrck toggles every 24 bck; each left-load gives l_din=r_din=0, underrun pulse; underrun_cnt = 1, 2, 3 ...
- Push (L=24'h200000, R=-24'h200000) before a left-load -> l_din=24'h200000 at the 1->0 toggle; r_din=24'hE00000 at the next 0->1; no underrun.
- Push 5 pairs with FIFO_DEPTH=4 and no pops -> s_ready=0 after the 4th pair; fifo_level=4; 5th pair is held by the source and enters after the next left-load.
- Push on the same edge as a left-load into an empty FIFO -> underrun pulse; the pair emits one frame later; fifo_level goes 0 -> 1 -> 0.
- rst=1 for one edge mid right half-frame with 3 pairs queued -> next edge shows lrck=0, fifo_level=0, underrun_cnt=0, l_din=r_din=0.
- Loopback framer -> i2s_tx -> i2s_rx with a square wave of +/-2097151 -> l_dout/r_dout reproduce the pushed sequence in order, with a fixed frame latency.
